// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA timing front end.
package vga_pkg;

    // Default 640x480@60 timing, in pixels (horizontal) and lines (vertical)
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Colour channel width to the DAC
    localparam int COLOR_W = 8;

    // Pin polarity encoding for hs/vs
    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    // Counters are 16 bit, so every axis total must fit
    localparam int MAX_TOTAL = 65535;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    // Length of one axis period: visible + front porch + sync + back porch
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    // Map an active-high sync level onto the pin polarity
    function automatic logic sync_pin(input logic level, input bit pol);
        return pol ? level : ~level;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis (x or y) of the raster: wrapping counter plus region decodes.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    output logic [15:0] o_count,
    output logic        o_wrap,
    output logic        o_active,
    output logic        o_sync
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    generate
        if (TOTAL > MAX_TOTAL || TOTAL < 1) begin : g_bad_total
            $error("vga_axis_counter: axis total %0d does not fit a 16-bit counter", TOTAL);
        end
    endgenerate

    localparam logic [15:0] LAST       = 16'(TOTAL - 1);
    localparam logic [15:0] ACT_END    = 16'(ACTIVE);
    localparam logic [15:0] SYNC_FIRST = 16'(ACTIVE + FP);
    localparam logic [15:0] SYNC_LAST  = 16'(ACTIVE + FP + SYNC - 1);

    // Region decodes straight off the count register, no added delay
    always_comb begin
        o_wrap   = (o_count == LAST);
        o_active = (o_count < ACT_END);
        o_sync   = (SYNC != 0) && (o_count >= SYNC_FIRST) && (o_count <= SYNC_LAST);
    end

    // Advance on enable, wrapping after the last position of the period
    // NOTE: async reset lives in the sensitivity list; state updates use <= so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_count <= '0;
        end else if (i_en) begin
            o_count <= o_wrap ? '0 : o_count + 16'd1;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// VGA raster counters plus the registered, blanked colour/sync output stage.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_pix_en,
    output logic [15:0]        o_x,
    output logic [15:0]        o_y,
    output logic               o_active,
    output logic               o_v_sync,
    output logic               o_frame,
    input  logic [COLOR_W-1:0] i_red,
    input  logic [COLOR_W-1:0] i_green,
    input  logic [COLOR_W-1:0] i_blue,
    output logic [COLOR_W-1:0] o_vga_r,
    output logic [COLOR_W-1:0] o_vga_g,
    output logic [COLOR_W-1:0] o_vga_b,
    output logic               o_vga_hs,
    output logic               o_vga_vs
);

    // Last visible line; the step leaving it starts vertical blanking
    localparam logic [15:0] V_LAST_ACTIVE = 16'(V_ACTIVE - 1);

    logic x_wrap, y_wrap;
    logic x_active, y_active;
    logic h_sync;
    logic frame_load;
    rgb_t pix_q;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_x (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (i_pix_en),
        .o_count  (o_x),
        .o_wrap   (x_wrap),
        .o_active (x_active),
        .o_sync   (h_sync)
    );

    // y only moves on the line carry from x
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_y (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (i_pix_en & x_wrap),
        .o_count  (o_y),
        .o_wrap   (y_wrap),
        .o_active (y_active),
        .o_sync   (o_v_sync)
    );

    // Visible area and the step that loads (0, V_ACTIVE); a frame wrap never loads it
    always_comb begin
        o_active   = x_active & y_active;
        frame_load = i_pix_en & x_wrap & ~y_wrap & (o_y == V_LAST_ACTIVE);
    end

    // Frame pulse: set by the loading step, cleared on the very next clock
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_frame <= 1'b0;
        end else begin
            o_frame <= frame_load;
        end
    end

    // Output stage: colour blanked outside the visible area, sync at pin polarity
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pix_q    <= '0;
            o_vga_hs <= ~SYNC_POL;
            o_vga_vs <= ~SYNC_POL;
        end else if (i_pix_en) begin
            pix_q    <= o_active ? rgb_t'({i_red, i_green, i_blue}) : '0;
            o_vga_hs <= sync_pin(h_sync, SYNC_POL);
            o_vga_vs <= sync_pin(o_v_sync, SYNC_POL);
        end
    end

    assign o_vga_r = pix_q.r;
    assign o_vga_g = pix_q.g;
    assign o_vga_b = pix_q.b;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default 640x480 instance with active-low sync and a
// tiny-raster instance with active-high sync, both checked every cycle against
// a position-counting model.
module tb_vga_timing;

    // Index 0: default timing, SYNC_POL=0. Index 1: 15x8 raster, SYNC_POL=1.
    localparam int HA[2]  = '{640, 8};
    localparam int HF[2]  = '{16, 2};
    localparam int HS[2]  = '{96, 3};
    localparam int HB[2]  = '{48, 2};
    localparam int VA[2]  = '{480, 4};
    localparam int VF[2]  = '{10, 1};
    localparam int VS[2]  = '{2, 2};
    localparam int VB[2]  = '{33, 1};
    localparam int POL[2] = '{0, 1};

    logic clk = 1'b0;
    logic rst;
    logic pix_en;
    logic [7:0] red, green, blue;

    logic [15:0] ox[2], oy[2];
    logic        oact[2], ovs[2], ofr[2], hs[2], vs[2];
    logic [7:0]  r[2], g[2], b[2];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    vga_timing u_dut (
        .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en),
        .o_x(ox[0]), .o_y(oy[0]), .o_active(oact[0]), .o_v_sync(ovs[0]), .o_frame(ofr[0]),
        .i_red(red), .i_green(green), .i_blue(blue),
        .o_vga_r(r[0]), .o_vga_g(g[0]), .o_vga_b(b[0]),
        .o_vga_hs(hs[0]), .o_vga_vs(vs[0])
    );

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1)
    ) u_small (
        .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en),
        .o_x(ox[1]), .o_y(oy[1]), .o_active(oact[1]), .o_v_sync(ovs[1]), .o_frame(ofr[1]),
        .i_red(red), .i_green(green), .i_blue(blue),
        .o_vga_r(r[1]), .o_vga_g(g[1]), .o_vga_b(b[1]),
        .o_vga_hs(hs[1]), .o_vga_vs(vs[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    longint     n[2];           // enabled steps since reset
    logic [23:0] m_rgb[2];
    logic        m_hs[2], m_vs[2], m_fr[2];

    function automatic int h_total(input int d);
        return HA[d] + HF[d] + HS[d] + HB[d];
    endfunction

    function automatic int v_total(input int d);
        return VA[d] + VF[d] + VS[d] + VB[d];
    endfunction

    function automatic int pos_x(input int d, input longint steps);
        return int'(steps % longint'(h_total(d)));
    endfunction

    function automatic int pos_y(input int d, input longint steps);
        return int'((steps / longint'(h_total(d))) % longint'(v_total(d)));
    endfunction

    function automatic bit in_range(input int v, input int lo, input int len);
        return (v >= lo) && (v < lo + len);
    endfunction

    // Inputs change 1 time unit after each falling edge, so at the falling
    // edge they still hold what the preceding rising edge sampled.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int x, y;
            bit act;
            logic [60:0] exp_v, act_v;
            if (rst) begin
                n[d]     = 0;
                m_rgb[d] = '0;
                m_hs[d]  = (POL[d] == 0);
                m_vs[d]  = (POL[d] == 0);
                m_fr[d]  = 1'b0;
            end else if (pix_en) begin
                x   = pos_x(d, n[d]);
                y   = pos_y(d, n[d]);
                act = (x < HA[d]) && (y < VA[d]);
                m_rgb[d] = act ? {red, green, blue} : 24'h0;
                m_hs[d]  = in_range(x, HA[d] + HF[d], HS[d]) ^ (POL[d] == 0);
                m_vs[d]  = in_range(y, VA[d] + VF[d], VS[d]) ^ (POL[d] == 0);
                n[d]++;
                m_fr[d]  = (pos_x(d, n[d]) == 0) && (pos_y(d, n[d]) == VA[d]);
            end else begin
                m_fr[d] = 1'b0;
            end
            x   = pos_x(d, n[d]);
            y   = pos_y(d, n[d]);
            act = (x < HA[d]) && (y < VA[d]);
            exp_v = {16'(x), 16'(y), act, in_range(y, VA[d] + VF[d], VS[d]), m_fr[d],
                     m_rgb[d], m_hs[d], m_vs[d]};
            act_v = {ox[d], oy[d], oact[d], ovs[d], ofr[d], r[d], g[d], b[d], hs[d], vs[d]};
            check(d == 0 ? "default outputs" : "small outputs", 64'(act_v), 64'(exp_v));
        end
    end

    // ---------------- stimulus ----------------
    // Drive inputs for the next rising edge, then land just after the falling edge
    task automatic tick(input bit en, input bit white);
        pix_en = en;
        {red, green, blue} = white ? 24'hFFFFFF : 24'($urandom);
        @(negedge clk);
        #1;
    endtask

    initial begin
        int low_cnt, first_low_x, prev_x, vs_hi, pulses, pulse_ok, stable_bad, doubles;
        bit wrapped, prev_fr;
        longint start_pos, end_pos;
        logic [25:0] held;

        rst = 1'b1;
        pix_en = 1'b0;
        {red, green, blue} = '0;
        repeat (3) tick(1'b1, 1'b0);

        // Reset values
        check("reset x", 64'(ox[0]), 64'd0);
        check("reset y", 64'(oy[0]), 64'd0);
        check("reset active", 64'(oact[0]), 64'd1);
        check("reset frame", 64'(ofr[0]), 64'd0);
        check("reset rgb", 64'({r[0], g[0], b[0]}), 64'd0);
        check("reset hs low-pol idle", 64'(hs[0]), 64'd1);
        check("reset vs low-pol idle", 64'(vs[0]), 64'd1);
        check("reset hs high-pol idle", 64'(hs[1]), 64'd0);
        check("reset vs high-pol idle", 64'(vs[1]), 64'd0);

        // First count after release
        rst = 1'b0;
        check("x after release", 64'(ox[0]), 64'd0);
        tick(1'b1, 1'b1);
        check("x step 1", 64'(ox[0]), 64'd1);
        tick(1'b1, 1'b1);
        check("x step 2", 64'(ox[0]), 64'd2);

        // One full line at one pixel per clock with white input
        low_cnt = 0; first_low_x = -1; wrapped = 0; prev_x = int'(ox[0]);
        for (int i = 0; i < 800; i++) begin
            tick(1'b1, 1'b1);
            if (!hs[0]) begin
                low_cnt++;
                if (first_low_x < 0) first_low_x = int'(ox[0]);
            end
            if (prev_x == 799 && ox[0] == 16'd0) wrapped = 1;
            if (ox[0] == 16'd1)   check("white at x0", 64'(r[0]), 64'hFF);
            if (ox[0] == 16'd640) check("white at x639", 64'(g[0]), 64'hFF);
            if (ox[0] == 16'd641) check("blank at x640", 64'(b[0]), 64'h0);
            prev_x = int'(ox[0]);
        end
        check("hs low count", 64'(low_cnt), 64'd96);
        check("hs first low lag", 64'(first_low_x), 64'd657);
        check("x wrapped 799->0", 64'(wrapped), 64'd1);
        check("y after line", 64'(oy[0]), 64'd1);

        // Asynchronous reset in the middle of hsync
        for (int i = 0; i < 1000 && ox[0] != 16'd700; i++) tick(1'b1, 1'b0);
        check("seek x700", 64'(ox[0]), 64'd700);
        check("hs low at x700", 64'(hs[0]), 64'd0);
        rst = 1'b1;
        #1;
        check("async rst x", 64'(ox[0]), 64'd0);
        check("async rst y", 64'(oy[0]), 64'd0);
        check("async rst hs", 64'(hs[0]), 64'd1);
        check("async rst rgb", 64'({r[0], g[0], b[0]}), 64'd0);
        check("async rst active", 64'(oact[0]), 64'd1);
        repeat (2) tick(1'b0, 1'b0);
        rst = 1'b0;

        // Random duty cycle and colours
        repeat (6000) tick($urandom_range(0, 2) != 0, 1'b0);

        // Enable every 4th clock
        start_pos = longint'(oy[0]) * 800 + longint'(ox[0]);
        pulses = 0; stable_bad = 0; doubles = 0; prev_fr = ofr[1];
        for (int i = 0; i < 400; i++) begin
            tick(1'b1, 1'b0);
            held = {r[0], g[0], hs[0], hs[1]};
            if (ofr[1]) pulses++;
            if (ofr[1] && prev_fr) doubles++;
            prev_fr = ofr[1];
            for (int k = 0; k < 3; k++) begin
                tick(1'b0, 1'b0);
                if ({r[0], g[0], hs[0], hs[1]} != held) stable_bad++;
                if (ofr[1]) pulses++;
                if (ofr[1] && prev_fr) doubles++;
                prev_fr = ofr[1];
            end
        end
        end_pos = (start_pos + 400) % (800 * 525);
        check("quarter-rate x", 64'(ox[0]), 64'(end_pos % 800));
        check("quarter-rate y", 64'(oy[0]), 64'(end_pos / 800));
        check("pins stable between enables", 64'(stable_bad), 64'd0);
        check("frame one clock wide", 64'(doubles), 64'd0);
        pulse_ok = (pulses == 3 || pulses == 4) ? 1 : 0;
        check("frame pulses in 400 steps", 64'(pulse_ok), 64'd1);

        // One full small frame from reset at one pixel per clock
        rst = 1'b1;
        tick(1'b0, 1'b0);
        rst = 1'b0;
        vs_hi = 0; pulses = 0; pulse_ok = 0;
        for (int i = 0; i < 120; i++) begin
            tick(1'b1, 1'b0);
            if (vs[1]) vs_hi++;
            if (ofr[1]) begin
                pulses++;
                if (ox[1] == 16'd0 && oy[1] == 16'd4) pulse_ok = 1;
            end
        end
        check("small vs high count", 64'(vs_hi), 64'd30);
        check("small frame pulses", 64'(pulses), 64'd1);
        check("small frame at (0,4)", 64'(pulse_ok), 64'd1);
        check("small frame wrap x", 64'(ox[1]), 64'd0);
        check("small frame wrap y", 64'(oy[1]), 64'd0);
        check("default x after 120", 64'(ox[0]), 64'd120);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
